// File: rtl/bcd_ctr_multi.sv
// Multi-digit BCD up/down counter with clear, validated load,
// wrap or saturate at the limits, and terminal-count/overflow flags.
module bcd_ctr_multi #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]      count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;
   logic [W-1:0]      step_v;
   logic [W-1:0]      clamp_v;
   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] bad;
   logic              limit;

   // carry[i] means every digit below i is at its limit (9 up, 0 down)
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic [3:0] d, l, inc, dec;
      assign d   = count_q[4*i +: 4];
      assign l   = load_val[4*i +: 4];
      assign inc = (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign dec = (d == 4'd0) ? 4'd9 : d - 4'd1;
      assign carry[i+1] = carry[i] & (up ? (d == 4'd9) : (d == 4'd0));
      assign step_v[4*i +: 4] = !carry[i] ? d : (up ? inc : dec);
      assign bad[i] = (l > 4'd9);
      assign clamp_v[4*i +: 4] = bad[i] ? 4'd9 : l;
   end

   assign limit = carry[DIGITS];

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      priority case (1'b1)
         clear: count_d = '0;
         load: begin
            count_d = clamp_v;
            err_d   = |bad;
         end
         en: begin
            ovf_d = limit;
            if (!(SATURATE && limit)) count_d = step_v;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign count    = count_q;
   assign ovf      = ovf_q;
   assign load_err = err_q;
   assign tc       = en & limit;

endmodule

// File: tb/tb_bcd_ctr_multi.sv
// Bench for bcd_ctr_multi: wrap and saturate instances driven together,
// checked against an integer-valued reference model.
module tb_bcd_ctr_multi;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAX    = 99;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         en = 1'b0;
   logic         up = 1'b1;

   logic [W-1:0] cnt_w, cnt_s;
   logic         tc_w, tc_s, ovf_w, ovf_s, err_w, err_s;

   int n_chk  = 0;
   int n_pass = 0;

   int mv[2];
   bit movf[2];
   bit merr[2];

   always #5 clk = ~clk;

   bcd_ctr_multi #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_w (
      .clk(clk), .reset(reset), .clear(clear), .load(load),
      .load_val(load_val), .en(en), .up(up),
      .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .load_err(err_w)
   );

   bcd_ctr_multi #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .load(load),
      .load_val(load_val), .en(en), .up(up),
      .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .load_err(err_s)
   );

   function automatic logic [W-1:0] to_bcd(int v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic chk(string tag, int got, int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         mv[s] = 0; movf[s] = 0; merr[s] = 0;
      end
   endtask

   // decimal-value model of one clock edge using the held inputs
   task automatic model_edge();
      int lv, mul, d;
      bit e;
      lv = 0; mul = 1; e = 0;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(load_val[4*i +: 4]);
         if (d > 9) begin d = 9; e = 1; end
         lv += d * mul;
         mul *= 10;
      end
      for (int s = 0; s < 2; s++) begin
         movf[s] = 0; merr[s] = 0;
         if (clear) mv[s] = 0;
         else if (load) begin mv[s] = lv; merr[s] = e; end
         else if (en && up) begin
            if (mv[s] == MAX) begin
               movf[s] = 1;
               if (s == 0) mv[s] = 0;
            end else mv[s] = mv[s] + 1;
         end else if (en) begin
            if (mv[s] == 0) begin
               movf[s] = 1;
               if (s == 0) mv[s] = MAX;
            end else mv[s] = mv[s] - 1;
         end
      end
   endtask

   task automatic check_tc(string tag);
      bit ew, es;
      ew = en && (up ? mv[0] == MAX : mv[0] == 0);
      es = en && (up ? mv[1] == MAX : mv[1] == 0);
      chk({tag, ".tc_w"}, int'(tc_w), int'(ew));
      chk({tag, ".tc_s"}, int'(tc_s), int'(es));
   endtask

   task automatic check_regs(string tag);
      chk({tag, ".cnt_w"}, int'(cnt_w), int'(to_bcd(mv[0])));
      chk({tag, ".cnt_s"}, int'(cnt_s), int'(to_bcd(mv[1])));
      chk({tag, ".ovf_w"}, int'(ovf_w), int'(movf[0]));
      chk({tag, ".ovf_s"}, int'(ovf_s), int'(movf[1]));
      chk({tag, ".err_w"}, int'(err_w), int'(merr[0]));
      chk({tag, ".err_s"}, int'(err_s), int'(merr[1]));
   endtask

   // entered and left at posedge+1
   task automatic cycle(bit c, bit l, logic [W-1:0] lv, bit e, bit u,
                        string tag);
      clear = c; load = l; load_val = lv; en = e; up = u;
      #1;
      check_tc(tag);
      @(posedge clk);
      model_edge();
      #1;
      check_regs(tag);
   endtask

   initial begin
      int r, pick;
      logic [W-1:0] lv;
      model_reset();
      #12;
      check_regs("rst");
      reset = 1'b1;
      cycle(0, 0, '0, 0, 1, "idle");

      repeat (12) cycle(0, 0, '0, 1, 1, "t1_up");
      chk("t1_twelve", int'(cnt_w), 8'h12);

      // asynchronous reset in the middle of a cycle
      en = 1'b1; up = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_regs("t1_async");
      en = 1'b0;
      #1;
      reset = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      check_regs("t1_rel");

      cycle(0, 1, 8'h98, 0, 1, "t2_ld");
      cycle(0, 0, '0, 1, 1, "t2_99");
      cycle(0, 0, '0, 1, 1, "t2_wrap");
      chk("t2_zero", int'(cnt_w), 8'h00);
      cycle(0, 0, '0, 0, 1, "t2_ovf_off");

      cycle(0, 1, 8'h01, 0, 0, "t3_ld");
      cycle(0, 0, '0, 1, 0, "t3_00");
      cycle(0, 0, '0, 1, 0, "t3_wrap");
      chk("t3_99", int'(cnt_w), 8'h99);
      cycle(0, 0, '0, 1, 1, "t3_dir");

      cycle(0, 1, 8'hA7, 0, 1, "t4_bad");
      chk("t4_clamp", int'(cnt_w), 8'h97);
      cycle(0, 1, 8'h45, 0, 1, "t4_ok");
      cycle(0, 1, 8'hFF, 1, 0, "t4_ff");

      cycle(1, 1, 8'h33, 1, 1, "t5_clr");
      cycle(0, 1, 8'h33, 1, 1, "t5_ld");
      chk("t5_noinc", int'(cnt_w), 8'h33);

      cycle(0, 1, 8'h99, 0, 1, "t6_ld");
      repeat (3) cycle(0, 0, '0, 1, 1, "t6_up");
      chk("t6_hold", int'(cnt_s), 8'h99);
      cycle(0, 1, 8'h00, 0, 0, "t6_ld0");
      repeat (2) cycle(0, 0, '0, 1, 0, "t6_dn");

      for (int k = 0; k < 400; k++) begin
         r = int'($urandom % 16);
         if ($urandom % 2 == 1) lv = W'($urandom);
         else begin
            pick = int'($urandom % 4);
            lv = to_bcd(pick < 2 ? pick : MAX - 3 + pick);
         end
         cycle(r == 0, r < 3, lv, ($urandom % 4) != 0,
               ($urandom % 2) == 1, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
